// File: rtl/pll_lock_reset_ctrl_pkg.sv
// Shared types and helpers for the board-clock PLL lock / reset controller.
// The FSM state type is reused by anything that decodes the controller's debug state.
package soc_clk_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } pll_rst_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width that holds every value from 0 to max(cycle params)-1.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = max_int(max_int(a, b), max_int(c, d));
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_if.sv
// Signal bundle between the lock/reset controller (master) and its surroundings (slave).
// The PLL lock input is sampled through a synchronizer.
interface pll_lock_reset_ctrl_if
  import soc_clk_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  // No valid/ready pair here: reinit is sampled on every clk edge and one high
  // cycle requests one restart; there is no acknowledge, and outputs are plain levels.
  logic             pll_locked;
  logic             reinit;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_count;
  logic [CNT_W-1:0] timeout_count;
  pll_rst_state_t   state;

  modport master (
    input  pll_locked, reinit,
    output pll_rst, sys_rst, ready, lock_loss_count, timeout_count, state
  );

  modport slave (
    output pll_locked, reinit,
    input  pll_rst, sys_rst, ready, lock_loss_count, timeout_count, state
  );

endinterface

// File: rtl/pll_lock_reset_ctrl_sync_bit.sv
// Asynchronously reset N-flop synchronizer for a single-bit CDC input.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// PLL bring-up controller: pulses PLL RST, qualifies LOCK, and releases the SoC
// reset only after a stable lock plus a hold-off. Runs on the free-running board clock.
module pll_lock_reset_ctrl
  import soc_clk_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 25,
  parameter int LOCK_TIMEOUT_CYCLES = 250000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int CNT_W               = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_lock_reset_ctrl_if.master bus
);

  localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
  localparam logic [31:0] RST_LAST     = 32'(PLL_RST_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(RST_HOLD_CYCLES - 1);

  pll_rst_state_t state, next_state;
  logic [TW-1:0]  timer;
  logic [31:0]    timer_ext;
  logic           lock_s;
  logic           inc_loss;
  logic           inc_timeout;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

  assign timer_ext = 32'(timer);

  always_comb begin
    next_state  = state;
    inc_loss    = 1'b0;
    inc_timeout = 1'b0;
    case (state)
      PLLRST:    if (timer_ext == RST_LAST) next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) next_state = STABLE;
        else if (timer_ext == TIMEOUT_LAST) begin
          next_state  = PLLRST;
          inc_timeout = !bus.reinit;
        end
      end
      STABLE: begin
        if (!lock_s)                       next_state = WAIT_LOCK;
        else if (timer_ext == STABLE_LAST) next_state = HOLD;
      end
      HOLD: begin
        if (!lock_s)                     next_state = WAIT_LOCK;
        else if (timer_ext == HOLD_LAST) next_state = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          inc_loss   = 1'b1;
        end
      end
      default: next_state = PLLRST;
    endcase
    // A restart request overrides everything, but a coincident lock drop is still counted.
    if (bus.reinit) next_state = PLLRST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= PLLRST;
      timer               <= '0;
      bus.pll_rst         <= 1'b1;
      bus.sys_rst         <= 1'b1;
      bus.lock_loss_count <= '0;
      bus.timeout_count   <= '0;
    end else begin
      state       <= next_state;
      bus.pll_rst <= (next_state == PLLRST);
      bus.sys_rst <= (next_state != RUN);
      if (next_state != state || bus.reinit) timer <= '0;
      else if (state != RUN)                 timer <= timer + TW'(1);
      if (inc_loss && !(&bus.lock_loss_count))
        bus.lock_loss_count <= bus.lock_loss_count + CNT_W'(1);
      if (inc_timeout && !(&bus.timeout_count))
        bus.timeout_count <= bus.timeout_count + CNT_W'(1);
    end
  end

  assign bus.ready = ~bus.sys_rst;
  assign bus.state = state;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Bench for pll_lock_reset_ctrl: directed lock/drop/reinit sequences; every output
// change is matched against a queue of hand-computed (cycle, outputs) records.
module tb_pll_lock_reset_ctrl;
  import soc_clk_pkg::*;

  localparam int CNT_W = 8;
  localparam int OBS_W = 3 + 2 * CNT_W;
  localparam int REC_W = 16 + OBS_W;
  localparam logic [OBS_W-1:0] RST_OBS = {1'b1, 1'b1, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}};

  logic        clk;
  logic        rst;
  logic [15:0] cyc;
  int          vectors = 0;
  int          miscompares = 0;
  logic [REC_W-1:0] exp_q[$];

  pll_lock_reset_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_reset_ctrl #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (3),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .RST_HOLD_CYCLES     (4),
    .CNT_W               (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset / cycle stamp ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc == k for the whole cycle following the k-th rising edge after reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  function automatic logic [OBS_W-1:0] cur_obs();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.lock_loss_count, bus.timeout_count};
  endfunction

  function automatic logic [REC_W-1:0] ev(input int c, input logic p, input logic s,
                                          input int llc, input int toc);
    return {16'(c), p, s, ~s, CNT_W'(llc), CNT_W'(toc)};
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  task automatic wait_to(input int c);
    int guard;
    guard = 0;
    while (int'(cyc) < c) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_to: cyc=%0d never reached target=%0d", cyc, c);
        miscompares++;
        report();
        $fatal(1, "cycle budget exhausted");
      end
    end
    #1;
  endtask

  task automatic check_reset();
    logic [OBS_W-1:0] o;
    o = cur_obs();
    vectors++;
    if (o !== RST_OBS) begin
      miscompares++;
      $display("FAIL reset_values: got pll_rst=%b sys_rst=%b ready=%b loss=%0d to=%0d, want 1 1 0 0 0",
               o[OBS_W-1], o[OBS_W-2], o[OBS_W-3], o[2*CNT_W-1:CNT_W], o[CNT_W-1:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [OBS_W-1:0] prev, o;
    logic [REC_W-1:0] got, want;
    prev = RST_OBS;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = RST_OBS;
      end else begin
        o = cur_obs();
        if (o !== prev) begin
          vectors++;
          got = {cyc, o};
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change: cyc=%0d pll_rst=%b sys_rst=%b ready=%b loss=%0d to=%0d",
                     cyc, o[OBS_W-1], o[OBS_W-2], o[OBS_W-3], o[2*CNT_W-1:CNT_W], o[CNT_W-1:0]);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              miscompares++;
              $display("FAIL output_change: got cyc=%0d p=%b s=%b r=%b loss=%0d to=%0d, want cyc=%0d p=%b s=%b r=%b loss=%0d to=%0d",
                       got[REC_W-1:OBS_W], got[OBS_W-1], got[OBS_W-2], got[OBS_W-3],
                       got[2*CNT_W-1:CNT_W], got[CNT_W-1:0],
                       want[REC_W-1:OBS_W], want[OBS_W-1], want[OBS_W-2], want[OBS_W-3],
                       want[2*CNT_W-1:CNT_W], want[CNT_W-1:0]);
            end
          end
          prev = o;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int c;
    rst            = 1'b1;
    bus.pll_locked = 1'b1;
    bus.reinit     = 1'b0;

    // 1: clean bring-up with lock present throughout
    exp_q.push_back(ev(3, 1'b0, 1'b1, 0, 0));
    exp_q.push_back(ev(16, 1'b0, 1'b0, 0, 0));
    do_reset();
    wait_to(20);

    // 2: lock never arrives, PLL reset retried every 35 cycles
    bus.pll_locked = 1'b0;
    exp_q.push_back(ev(3, 1'b0, 1'b1, 0, 0));
    for (int n = 1; n <= 3; n++) begin
      exp_q.push_back(ev(35 * n, 1'b1, 1'b1, 0, n));
      exp_q.push_back(ev(35 * n + 3, 1'b0, 1'b1, 0, n));
    end
    do_reset();
    wait_to(110);

    // 3: one-cycle lock glitch while STABLE restarts qualification
    bus.pll_locked = 1'b1;
    exp_q.push_back(ev(3, 1'b0, 1'b1, 0, 0));
    exp_q.push_back(ev(21, 1'b0, 1'b0, 0, 0));
    do_reset();
    wait_to(5);
    bus.pll_locked = 1'b0;
    wait_to(6);
    bus.pll_locked = 1'b1;

    // 4: lock drop in RUN, then relock
    exp_q.push_back(ev(33, 1'b0, 1'b1, 1, 0));
    exp_q.push_back(ev(55, 1'b0, 1'b0, 1, 0));
    wait_to(30);
    bus.pll_locked = 1'b0;
    wait_to(40);
    bus.pll_locked = 1'b1;

    // 5: second drop, relock, then rst while in HOLD; bring-up must repeat case 1
    exp_q.push_back(ev(63, 1'b0, 1'b1, 2, 0));
    wait_to(60);
    bus.pll_locked = 1'b0;
    wait_to(70);
    bus.pll_locked = 1'b1;
    wait_to(83);
    exp_q.push_back(ev(3, 1'b0, 1'b1, 0, 0));
    exp_q.push_back(ev(16, 1'b0, 1'b0, 0, 0));
    do_reset();

    // 6: 300 drops in RUN saturate the loss counter at 255
    for (int n = 1; n <= 300; n++) begin
      b = 20 + 22 * (n - 1);
      exp_q.push_back(ev(b + 3, 1'b0, 1'b1, sat(n), 0));
      exp_q.push_back(ev(b + 20, 1'b0, 1'b0, sat(n), 0));
      wait_to(b);
      bus.pll_locked = 1'b0;
      wait_to(b + 5);
      bus.pll_locked = 1'b1;
    end

    // reinit pulse in RUN: three-cycle PLL reset, then full requalification
    c = 6640;
    exp_q.push_back(ev(c + 1, 1'b1, 1'b1, 255, 0));
    exp_q.push_back(ev(c + 4, 1'b0, 1'b1, 255, 0));
    exp_q.push_back(ev(c + 17, 1'b0, 1'b0, 255, 0));
    wait_to(c);
    bus.reinit = 1'b1;
    wait_to(c + 1);
    bus.reinit = 1'b0;
    wait_to(c + 30);

    if (exp_q.size() != 0) begin
      $display("FAIL missing_changes: %0d expected output changes never seen", exp_q.size());
      vectors     += exp_q.size();
      miscompares += exp_q.size();
    end
    report();
    $finish;
  end

endmodule
